// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the byte-enabled single-port RAM initiator.
// Optional bounds checking is enabled with the RAM_BOUNDS_CHECK_EN macro.
package ram_ctrl_pkg;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_kind_e;

  function automatic int rd_latency(input int out_regs);
    return 3 + out_regs;
  endfunction

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Circular response FIFO with wrap-around pointers.
// Used by singleport_ram_be_ctrl (bounds check via RAM_BOUNDS_CHECK_EN).
module ram_rsp_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [CW-1:0]     r_cnt;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop) begin
        r_rd <= nxt(r_rd);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd];
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/singleport_ram_be_ctrl.sv
// Request/response initiator for singleport_ram_be (input regs = 1).
// RAM_BOUNDS_CHECK_EN: block out-of-range RAM access, flag err_oob.
module singleport_ram_be_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int NUM_BE       = 1,
  parameter int WORDS        = 256,
  parameter int RAM_OUT_REGS = 0,
  parameter int RSP_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [NUM_BE-1:0] req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [NUM_BE-1:0] ram_re,
  output logic [NUM_BE-1:0] ram_we,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              err_oob
);

  localparam int LAT  = rd_latency(RAM_OUT_REGS);
  localparam int PIPE = LAT - 1;
  localparam int CW   = credit_w(RSP_DEPTH);

  if ((DATA_W % NUM_BE) != 0) begin : g_bad_be
    $error("DATA_W must be a multiple of NUM_BE");
  end
  if (WORDS < 1 || $clog2(WORDS) > ADDR_W) begin : g_bad_words
    $error("WORDS does not fit ADDR_W");
  end

  typedef struct packed {
    req_kind_e         kind;
    logic [NUM_BE-1:0] be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              w_req;
  logic              w_acc;
  logic              w_rd_acc;
  logic              w_oob;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [DATA_W-1:0] w_push_data;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [NUM_BE-1:0] r_re;
  logic [NUM_BE-1:0] r_we;
  logic              r_en;
  logic [PIPE-1:0]   r_pipe;
  logic [PIPE-1:0]   r_pipe_oob;
  logic [CW-1:0]     r_cred;

  assign w_req = '{
    kind:  req_we ? REQ_WR : REQ_RD,
    be:    req_be,
    addr:  req_addr,
    wdata: req_wdata
  };

`ifdef RAM_BOUNDS_CHECK_EN
  logic r_err;
  assign w_oob = (int'(w_req.addr) >= WORDS);
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_err <= 1'b0;
    end else if (w_acc && w_oob) begin
      r_err <= 1'b1;
    end
  end
  assign err_oob = r_err;
`else
  assign w_oob   = 1'b0;
  assign err_oob = 1'b0;
`endif

  // Writes bypass the credit check: they never produce a response.
  assign req_ready = a_rst &
    ((r_cred != '0) | (w_req.kind == REQ_WR));
  assign w_acc    = req_valid & req_ready;
  assign w_rd_acc = w_acc & (w_req.kind == REQ_RD);
  assign w_pop    = rsp_valid & rsp_ready;
  assign w_push   = r_pipe[PIPE-1];
  assign w_push_data =
    r_pipe_oob[PIPE-1] ? '0 : ram_data_out;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_re       <= '0;
      r_we       <= '0;
      r_en       <= 1'b0;
      r_pipe     <= '0;
      r_pipe_oob <= '0;
      r_cred     <= CW'(RSP_DEPTH);
    end else begin
      r_en <= 1'b1;
      r_re <= '0;
      r_we <= '0;
      if (w_acc) begin
        r_addr <= w_req.addr;
        r_data <= w_req.wdata;
        if (!w_oob) begin
          unique case (1'b1)
            (w_req.kind == REQ_WR): r_we <= w_req.be;
            default:                r_re <= '1;
          endcase
        end
      end
      r_pipe     <= {r_pipe[PIPE-2:0], w_rd_acc};
      r_pipe_oob <= {r_pipe_oob[PIPE-2:0],
                     w_rd_acc & w_oob};
      unique case ({w_rd_acc, w_pop})
        2'b10:   r_cred <= r_cred - 1'b1;
        2'b01:   r_cred <= r_cred + 1'b1;
        default: r_cred <= r_cred;
      endcase
    end
  end

  ram_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (a_rst),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (w_pop),
    .o_dout  (rsp_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign rsp_valid   = ~w_empty;
  assign ram_addr    = r_addr;
  assign ram_data_in = r_data;
  assign ram_re      = r_re;
  assign ram_we      = r_we;
  assign ram_en      = r_en;

`ifndef SYNTHESIS
  // Credits plus queued plus in-flight reads always equal the depth.
  always @(posedge clk) begin
    if (a_rst && w_push && w_full) begin
      $display("ram_rsp_fifo overflow");
      $finish;
    end
    if (a_rst && (int'(w_count) + $countones(r_pipe)
        + int'(r_cred)) != RSP_DEPTH) begin
      $display("ram_ctrl credit accounting broken");
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_singleport_ram_be_ctrl.sv
// Directed bench for singleport_ram_be_ctrl with behavioural RAMs.
// Bounds-check checks follow RAM_BOUNDS_CHECK_EN.
module tb_singleport_ram_be_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  // 8-bit, single byte-lane instance
  logic       req_valid, req_ready, req_we;
  logic [0:0] req_be;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [7:0] ram_addr, ram_data_in, ram_data_out;
  logic [0:0] ram_re, ram_we;
  logic       ram_en, err_oob;

  // 16-bit, two byte-lane instance
  logic        h_valid, h_ready, h_we;
  logic [1:0]  h_be;
  logic [7:0]  h_addr;
  logic [15:0] h_wdata;
  logic        h_rsp_valid, h_rsp_ready;
  logic [15:0] h_rdata;
  logic [7:0]  h_ram_addr;
  logic [15:0] h_ram_din, h_ram_dout;
  logic [1:0]  h_ram_re, h_ram_we;
  logic        h_ram_en, h_err;

  singleport_ram_be_ctrl #(
    .ADDR_W(8), .DATA_W(8), .NUM_BE(1),
    .WORDS(200), .RAM_OUT_REGS(0), .RSP_DEPTH(4)
  ) u_dut (
    .clk(clk), .a_rst(a_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_re(ram_re), .ram_we(ram_we), .ram_en(ram_en),
    .ram_data_out(ram_data_out), .err_oob(err_oob)
  );

  singleport_ram_be_ctrl #(
    .ADDR_W(8), .DATA_W(16), .NUM_BE(2),
    .WORDS(256), .RAM_OUT_REGS(0), .RSP_DEPTH(4)
  ) u_dut16 (
    .clk(clk), .a_rst(a_rst),
    .req_valid(h_valid), .req_ready(h_ready),
    .req_we(h_we), .req_be(h_be),
    .req_addr(h_addr), .req_wdata(h_wdata),
    .rsp_valid(h_rsp_valid), .rsp_ready(h_rsp_ready),
    .rsp_rdata(h_rdata),
    .ram_addr(h_ram_addr), .ram_data_in(h_ram_din),
    .ram_re(h_ram_re), .ram_we(h_ram_we), .ram_en(h_ram_en),
    .ram_data_out(h_ram_dout), .err_oob(h_err)
  );

  // Behavioural RAMs: inputs sampled at the edge, data valid next cycle
  logic [7:0]  mem8  [256];
  logic [15:0] mem16 [256];

  always @(posedge clk) begin
    if (ram_we[0]) mem8[ram_addr] <= ram_data_in;
    if (ram_re[0]) ram_data_out <= mem8[ram_addr];
  end

  always @(posedge clk) begin
    if (h_ram_we[0]) mem16[h_ram_addr][7:0]  <= h_ram_din[7:0];
    if (h_ram_we[1]) mem16[h_ram_addr][15:8] <= h_ram_din[15:8];
    if (|h_ram_re) h_ram_dout <= mem16[h_ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_be = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b0;
    h_valid = 1'b0; h_we = 1'b0; h_be = 2'b00;
    h_addr = 8'h00; h_wdata = 16'h0; h_rsp_ready = 1'b0;
    #1 a_rst = 1'b0;
    #11;
    n_cmp++;
    if (ram_re !== 1'b0) begin
      n_mis++; $display("FAIL rst_re: got %b want 0", ram_re);
    end
    n_cmp++;
    if (ram_we !== 1'b0) begin
      n_mis++; $display("FAIL rst_we: got %b want 0", ram_we);
    end
    n_cmp++;
    if (ram_addr !== 8'h00 || ram_data_in !== 8'h00) begin
      n_mis++;
      $display("FAIL rst_addr_data: got %h/%h want 00/00",
               ram_addr, ram_data_in);
    end
    n_cmp++;
    if (ram_en !== 1'b0) begin
      n_mis++; $display("FAIL rst_en: got %b want 0", ram_en);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
      n_mis++;
      $display("FAIL rst_rsp: got %b/%h want 0/00",
               rsp_valid, rsp_rdata);
    end
    n_cmp++;
    if (err_oob !== 1'b0) begin
      n_mis++; $display("FAIL rst_err: got %b want 0", err_oob);
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_ready: got %b want 0", req_ready);
    end
    req_valid = 1'b0;
    @(negedge clk);
    a_rst = 1'b1;
    tick();
    n_cmp++;
    if (ram_en !== 1'b1 || req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL post_rst: got en=%b rdy=%b want 1/1",
               ram_en, req_ready);
    end
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_we = 1'b1; req_be = 1'b1;
    req_addr = 8'h10; req_wdata = 8'hA5;
    tick();
    n_cmp++;
    if (ram_we !== 1'b1 || ram_re !== 1'b0 ||
        ram_addr !== 8'h10 || ram_data_in !== 8'hA5) begin
      n_mis++;
      $display("FAIL wr_drive: got we=%b re=%b a=%h d=%h want 1 0 10 a5",
               ram_we, ram_re, ram_addr, ram_data_in);
    end
    req_we = 1'b0; rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (ram_re !== 1'b1 || ram_we !== 1'b0) begin
      n_mis++;
      $display("FAIL rd_drive: got re=%b we=%b want 1/0",
               ram_re, ram_we);
    end
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || ram_re !== 1'b0) begin
      n_mis++;
      $display("FAIL rd_early: got v=%b re=%b want 0/0",
               rsp_valid, ram_re);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      n_mis++;
      $display("FAIL rd_lat3: got v=%b d=%h want 1/a5",
               rsp_valid, rsp_rdata);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL rd_pop: got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_byte_enable();
    h_valid = 1'b1; h_we = 1'b1; h_be = 2'b11;
    h_addr = 8'h05; h_wdata = 16'h1234;
    tick();
    h_be = 2'b10; h_wdata = 16'hABCD;
    tick();
    n_cmp++;
    if (h_ram_we !== 2'b10) begin
      n_mis++;
      $display("FAIL be_we: got %b want 10", h_ram_we);
    end
    h_we = 1'b0; h_rsp_ready = 1'b1;
    tick();
    h_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (h_rsp_valid !== 1'b1 || h_rdata !== 16'hAB34) begin
      n_mis++;
      $display("FAIL be_merge: got v=%b d=%h want 1/ab34",
               h_rsp_valid, h_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int idx;
    int got;
    logic acc;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_be = 1'b1;
      req_addr = 8'(8'h20 + i); req_wdata = 8'(8'h30 + i);
      tick();
    end
    req_we = 1'b0; rsp_ready = 1'b0; idx = 0;
    for (int c = 0; c < 12; c++) begin
      req_addr = 8'(8'h20 + idx);
      #1;
      if (req_ready) idx++;
      tick();
    end
    n_cmp++;
    if (idx != 4) begin
      n_mis++;
      $display("FAIL bp_accepted: got %0d want 4", idx);
    end
    req_addr = 8'(8'h20 + idx);
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL bp_ready: got %b want 0", req_ready);
    end
    rsp_ready = 1'b1; got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      req_valid = (idx < 10);
      req_addr = 8'(8'h20 + idx);
      #1;
      acc = req_valid & req_ready;
      if (rsp_valid) begin
        n_cmp++;
        if (rsp_rdata !== 8'(8'h30 + got)) begin
          n_mis++;
          $display("FAIL bp_order[%0d]: got %h want %h",
                   got, rsp_rdata, 8'(8'h30 + got));
        end
        got++;
      end
      tick();
      if (acc) idx++;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (got != 10) begin
      n_mis++;
      $display("FAIL bp_count: got %0d want 10", got);
    end
    tick();
  endtask

  task automatic test_write_priority();
    int n;
    int got;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
    req_addr = 8'h20; n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready) n++;
      tick();
    end
    n_cmp++;
    if (n != 4) begin
      n_mis++;
      $display("FAIL wp_fill: got %0d want 4", n);
    end
    req_we = 1'b1; req_be = 1'b1;
    req_addr = 8'h40; req_wdata = 8'h77;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL wp_ready: got %b want 1", req_ready);
    end
    tick();
    n_cmp++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h40) begin
      n_mis++;
      $display("FAIL wp_we: got we=%b a=%h want 1/40",
               ram_we, ram_addr);
    end
    req_valid = 1'b0; rsp_ready = 1'b1; got = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) got++;
      tick();
    end
    n_cmp++;
    if (got != 4) begin
      n_mis++;
      $display("FAIL wp_drain: got %0d want 4", got);
    end
  endtask

  task automatic test_reset_inflight();
    int saw;
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    req_addr = 8'h10;
    tick();
    tick();
    req_valid = 1'b0;
    #2 a_rst = 1'b0;
    #1;
    n_cmp++;
    if (ram_re !== 1'b0 || rsp_valid !== 1'b0 ||
        req_ready !== 1'b0 || ram_en !== 1'b0 ||
        ram_addr !== 8'h00) begin
      n_mis++;
      $display("FAIL rst_mid: got re=%b v=%b rdy=%b en=%b a=%h want 0 0 0 0 00",
               ram_re, rsp_valid, req_ready, ram_en, ram_addr);
    end
    @(negedge clk);
    a_rst = 1'b1;
    saw = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rsp_valid) saw++;
    end
    n_cmp++;
    if (saw != 0) begin
      n_mis++;
      $display("FAIL rst_ghost: got %0d responses want 0", saw);
    end
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      n_mis++;
      $display("FAIL rst_newrd: got v=%b d=%h want 1/a5",
               rsp_valid, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_oob();
    rsp_ready = 1'b1;
`ifdef RAM_BOUNDS_CHECK_EN
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hF0;
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if (ram_re !== 1'b0 || err_oob !== 1'b1) begin
      n_mis++;
      $display("FAIL oob_block: got re=%b err=%b want 0/1",
               ram_re, err_oob);
    end
    tick();
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
      n_mis++;
      $display("FAIL oob_rsp: got v=%b d=%h want 1/00",
               rsp_valid, rsp_rdata);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (err_oob !== 1'b1) begin
      n_mis++;
      $display("FAIL oob_sticky: got %b want 1", err_oob);
    end
`else
    req_valid = 1'b1; req_we = 1'b1; req_be = 1'b1;
    req_addr = 8'hF0; req_wdata = 8'h5C;
    tick();
    req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if (ram_re !== 1'b1 || err_oob !== 1'b0) begin
      n_mis++;
      $display("FAIL nochk_rd: got re=%b err=%b want 1/0",
               ram_re, err_oob);
    end
    tick();
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5C) begin
      n_mis++;
      $display("FAIL nochk_rsp: got v=%b d=%h want 1/5c",
               rsp_valid, rsp_rdata);
    end
    tick();
    n_cmp++;
    if (err_oob !== 1'b0) begin
      n_mis++;
      $display("FAIL nochk_err: got %b want 0", err_oob);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_write_priority();
    test_reset_inflight();
    test_oob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
